// File: rtl/vt52_pkg.sv
// Shared constants for the VT52 transmit path: identify reply bytes,
// reply length and the arbiter FSM state encoding.
package vt52_pkg;

  localparam logic [7:0] RSP_BYTE0 = 8'h1B;  // ESC
  localparam logic [7:0] RSP_BYTE1 = 8'h2F;  // '/'
  localparam logic [7:0] RSP_BYTE2 = 8'h4B;  // 'K'

  localparam int         RSP_LEN      = 3;
  localparam logic [1:0] RSP_LAST_IDX = 2'(RSP_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KBD  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

  // Reply byte at a given index of the identify sequence.
  function automatic logic [7:0] rsp_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return RSP_BYTE0;
      2'd1:    return RSP_BYTE1;
      default: return RSP_BYTE2;
    endcase
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, DEPTH entries (power of two >= 2). Pointers wrap naturally
// modulo DEPTH; count is one bit wider so "full" is representable.
// Push when full and pop when empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  // Next pointers and count; simultaneous push and pop keep count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates the UART transmitter between buffered keyboard bytes and the
// three-byte VT52 identify reply. The reply wins in IDLE and is sent
// atomically; keyboard bytes keep filling the FIFO meanwhile.
//
// Handshakes: a keyboard push happens on a clock edge where kbd_valid and
// kbd_ready are both high; a UART transfer happens on an edge where
// uart_tx_valid and uart_tx_ready are both high. Once uart_tx_valid is
// raised, uart_tx_data and owner hold until that transfer.
module tx_arbiter
  import vt52_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] kbd_data,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  input  logic       rsp_req,
  output logic       rsp_busy,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready,
  output logic       owner
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  arb_state_e    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          owner_q, owner_d;
  logic          pend_q, pend_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count_unused;
  logic          xfer;

  assign kbd_ready     = !fifo_full;
  assign fifo_push     = kbd_valid && kbd_ready;
  assign xfer          = valid_q && uart_tx_ready;
  assign rsp_busy      = pend_q || (state_q == ST_RSP);
  assign uart_tx_data  = data_q;
  assign uart_tx_valid = valid_q;
  assign owner         = owner_q;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (kbd_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  // Next-state and output-register logic. A request that lands while the
  // pending flag is being consumed merges into the reply starting now; a
  // request during the final reply byte finds the flag already clear and
  // therefore queues a fresh reply.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    owner_d  = owner_q;
    pend_d   = pend_q;
    fifo_pop = 1'b0;

    if (rsp_req) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          data_d  = RSP_BYTE0;
          valid_d = 1'b1;
          idx_d   = 2'd0;
          owner_d = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_RSP;
        end else if (!fifo_empty) begin
          data_d   = fifo_rd_data;
          fifo_pop = 1'b1;
          valid_d  = 1'b1;
          owner_d  = 1'b0;
          state_d  = ST_KBD;
        end
      end
      ST_KBD: begin
        if (xfer) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RSP: begin
        if (xfer) begin
          if (idx_q == RSP_LAST_IDX) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = rsp_byte(idx_q + 2'd1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM state, reply index, pending flag and UART output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      owner_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: expected {owner, data} words are queued when
// stimulus is driven; a negedge monitor records each UART transfer with
// its cycle number and every scenario task compares the two queues.
module tb_tx_arbiter;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_valid = 1'b0;
  logic       kbd_ready;
  logic       rsp_req = 1'b0;
  logic       rsp_busy;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready = 1'b0;
  logic       owner;

  typedef struct {
    logic [8:0] v;
    int         c;
  } obs_t;

  logic [8:0] exp_q[$];
  obs_t       obs_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  tx_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .kbd_data      (kbd_data),
    .kbd_valid     (kbd_valid),
    .kbd_ready     (kbd_ready),
    .rsp_req       (rsp_req),
    .rsp_busy      (rsp_busy),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .owner         (owner)
  );

  // Clock and reset: 25 MHz clock, cycle counter.
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a transfer is due at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && uart_tx_valid === 1'b1 && uart_tx_ready === 1'b1)
      obs_q.push_back('{v: {owner, uart_tx_data}, c: cyc});
  end

  initial begin
    #5ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_obs(input int k, input int budget);
    for (int i = 0; i < budget && obs_q.size() < k; i++) tick(1);
  endtask

  task automatic push_byte(input logic [7:0] d, output bit ok);
    kbd_data  = d;
    kbd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (kbd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    kbd_valid = 1'b0;
  endtask

  task automatic pulse_req();
    rsp_req = 1'b1;
    tick(1);
    rsp_req = 1'b0;
  endtask

  task automatic flush();
    exp_q.delete();
    obs_q.delete();
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", uart_tx_valid); end
    total++; if (uart_tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", uart_tx_data); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b want=0", owner); end
    total++; if (kbd_ready !== 1'b1) begin bad++; $display("FAIL reset_kbd_ready got=%b want=1", kbd_ready); end
    total++; if (rsp_busy !== 1'b0) begin bad++; $display("FAIL reset_rsp_busy got=%b want=0", rsp_busy); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_kbd_single();
    int   n;
    obs_t o;
    logic [8:0] e;
    uart_tx_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h41});
    kbd_data = 8'h41; kbd_valid = 1'b1; n = cyc;
    tick(1);
    kbd_valid = 1'b0;
    wait_obs(1, 20);
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL c1_count got=%0d want=1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.v !== e) begin bad++; $display("FAIL c1_word got=%h want=%h", o.v, e); end
      total++; if (o.c != n + 2) begin bad++; $display("FAIL c1_latency got=%0d want=%0d", o.c - n, 2); end
    end
    @(negedge clk);
    total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL c1_one_cycle got=%b want=0", uart_tx_valid); end
    tick(2);
    flush();
  endtask

  task automatic test_reply();
    int   n;
    obs_t o;
    logic [8:0] e;
    uart_tx_ready = 1'b1;
    exp_q.push_back({1'b1, 8'h1B});
    exp_q.push_back({1'b1, 8'h2F});
    exp_q.push_back({1'b1, 8'h4B});
    rsp_req = 1'b1; n = cyc;
    tick(1);
    rsp_req = 1'b0;
    total++; if (rsp_busy !== 1'b1) begin bad++; $display("FAIL c2_busy_set got=%b want=1", rsp_busy); end
    wait_obs(3, 20);
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL c2_count got=%0d want=3", obs_q.size()); end
    for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.v !== e) begin bad++; $display("FAIL c2_word%0d got=%h want=%h", i, o.v, e); end
      total++; if (o.c != n + 2 + i) begin bad++; $display("FAIL c2_cycle%0d got=%0d want=%0d", i, o.c - n, 2 + i); end
    end
    total++; if (rsp_busy !== 1'b0) begin bad++; $display("FAIL c2_busy_fall got=%b want=0", rsp_busy); end
    tick(2);
    flush();
  endtask

  task automatic test_backpressure();
    bit   ok;
    obs_t o;
    obs_t prev;
    logic [8:0] e;
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b0, 8'h30 + 8'(i)});
      push_byte(8'h30 + 8'(i), ok);
      total++; if (!ok) begin bad++; $display("FAIL c3_push%0d got=refused want=accepted", i); end
    end
    // 0x30 sits in the output register, 0x31..0x34 fill the FIFO.
    total++; if (kbd_ready !== 1'b0) begin bad++; $display("FAIL c3_full got=%b want=0", kbd_ready); end
    kbd_data = 8'h35; kbd_valid = 1'b1;
    tick(3);
    total++; if (kbd_ready !== 1'b0) begin bad++; $display("FAIL c3_hold got=%b want=0", kbd_ready); end
    total++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h30 || owner !== 1'b0) begin
      bad++; $display("FAIL c3_stall got=%b/%h/%b want=1/30/0", uart_tx_valid, uart_tx_data, owner);
    end
    uart_tx_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h35});
    push_byte(8'h35, ok);
    total++; if (!ok) begin bad++; $display("FAIL c3_late_push got=refused want=accepted"); end
    wait_obs(6, 100);
    total++; if (obs_q.size() != 6) begin bad++; $display("FAIL c3_count got=%0d want=6", obs_q.size()); end
    for (int i = 0; i < 6 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.v !== e) begin bad++; $display("FAIL c3_word%0d got=%h want=%h", i, o.v, e); end
      if (i > 0) begin
        total++; if (o.c - prev.c < 2) begin bad++; $display("FAIL c3_gap%0d got=%0d want>=2", i, o.c - prev.c); end
      end
      prev = o;
    end
    tick(2);
    flush();
  endtask

  task automatic test_reply_priority();
    bit   ok;
    obs_t o;
    logic [8:0] e;
    uart_tx_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b1, 8'h1B});
    exp_q.push_back({1'b1, 8'h2F});
    exp_q.push_back({1'b1, 8'h4B});
    exp_q.push_back({1'b0, 8'h61});
    push_byte(8'h5A, ok);
    tick(2);
    push_byte(8'h61, ok);
    pulse_req();
    tick(2);
    total++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h5A || owner !== 1'b0 || rsp_busy !== 1'b1) begin
      bad++; $display("FAIL c4_stall got=%b/%h/%b/%b want=1/5a/0/1", uart_tx_valid, uart_tx_data, owner, rsp_busy);
    end
    uart_tx_ready = 1'b1;
    wait_obs(5, 50);
    total++; if (obs_q.size() != 5) begin bad++; $display("FAIL c4_count got=%0d want=5", obs_q.size()); end
    for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.v !== e) begin bad++; $display("FAIL c4_word%0d got=%h want=%h", i, o.v, e); end
    end
    tick(2);
    flush();
  endtask

  task automatic test_req_merge();
    obs_t o;
    logic [8:0] e;
    uart_tx_ready = 1'b0;
    repeat (2) begin
      exp_q.push_back({1'b1, 8'h1B});
      exp_q.push_back({1'b1, 8'h2F});
      exp_q.push_back({1'b1, 8'h4B});
    end
    pulse_req();
    tick(3);
    repeat (3) begin
      pulse_req();
      tick(1);
    end
    uart_tx_ready = 1'b1;
    wait_obs(6, 50);
    tick(10);
    total++; if (obs_q.size() != 6) begin bad++; $display("FAIL c5_count got=%0d want=6", obs_q.size()); end
    for (int i = 0; i < 6 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.v !== e) begin bad++; $display("FAIL c5_word%0d got=%h want=%h", i, o.v, e); end
    end
    flush();
  endtask

  task automatic test_req_on_last();
    int   n;
    obs_t o;
    logic [8:0] e;
    uart_tx_ready = 1'b1;
    repeat (2) begin
      exp_q.push_back({1'b1, 8'h1B});
      exp_q.push_back({1'b1, 8'h2F});
      exp_q.push_back({1'b1, 8'h4B});
    end
    n = cyc;
    pulse_req();
    tick(3);
    // Cycle n+4 carries the final 0x4B transfer.
    pulse_req();
    wait_obs(6, 40);
    tick(10);
    total++; if (obs_q.size() != 6) begin bad++; $display("FAIL c5b_count got=%0d want=6", obs_q.size()); end
    for (int i = 0; i < 6 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.v !== e) begin bad++; $display("FAIL c5b_word%0d got=%h want=%h", i, o.v, e); end
      total++; if (o.c != n + 2 + i + (i >= 3 ? 1 : 0)) begin
        bad++; $display("FAIL c5b_cycle%0d got=%0d want=%0d", i, o.c - n, 2 + i + (i >= 3 ? 1 : 0));
      end
    end
    flush();
  endtask

  task automatic test_reset_mid_reply();
    obs_t o;
    logic [8:0] e;
    uart_tx_ready = 1'b1;
    exp_q.push_back({1'b1, 8'h1B});
    exp_q.push_back({1'b1, 8'h2F});
    pulse_req();
    tick(1);
    // A keyboard byte buffered during the reply must be lost by reset.
    kbd_data = 8'h77; kbd_valid = 1'b1;
    tick(1);
    kbd_valid = 1'b0;
    tick(1);
    rst_n = 1'b0;
    #1;
    total++;
    if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00 || owner !== 1'b0) begin
      bad++; $display("FAIL c6_outputs got=%b/%h/%b want=0/00/0", uart_tx_valid, uart_tx_data, owner);
    end
    total++;
    if (rsp_busy !== 1'b0 || kbd_ready !== 1'b1) begin
      bad++; $display("FAIL c6_derived got=%b/%b want=0/1", rsp_busy, kbd_ready);
    end
    tick(2);
    rst_n = 1'b1;
    tick(12);
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL c6_count got=%0d want=2", obs_q.size()); end
    for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.v !== e) begin bad++; $display("FAIL c6_word%0d got=%h want=%h", i, o.v, e); end
    end
    total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL c6_idle got=%b want=0", uart_tx_valid); end
    flush();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_kbd_single();
    test_reply();
    test_backpressure();
    test_reply_priority();
    test_req_merge();
    test_req_on_last();
    test_reset_mid_reply();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
